// File: rtl/signed_sat_accumulator_pkg.sv
// Shared definitions for the signed saturating burst accumulator:
// FSM state encoding and the signed range limits for a given width.
package signed_sat_accumulator_pkg;

    typedef enum logic {
        ACC = 1'b0,
        OUT = 1'b1
    } acc_state_e;

    // Largest positive value representable in 'width' bits, two's complement.
    function automatic int sat_max(input int width);
        return (1 << (width - 1)) - 1;
    endfunction

    // Most negative value representable in 'width' bits, two's complement.
    function automatic int sat_min(input int width);
        return -(1 << (width - 1));
    endfunction

endpackage

// File: rtl/signed_sat_accumulator_sat_add.sv
// Combinational signed add with clamp to the WIDTH-bit signed range.
// The sum is formed one bit wider so overflow shows as a disagreement
// between the two top bits; the top bit then tells which rail to use.
module sat_add
    import signed_sat_accumulator_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             clamped
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(sat_max(WIDTH));
    localparam logic [WIDTH-1:0] MIN_V = WIDTH'(sat_min(WIDTH));

    logic [WIDTH:0] wide;

    // Extended add, then select wrapped value or the appropriate rail.
    always_comb begin
        wide    = {a[WIDTH-1], a} + {b[WIDTH-1], b};
        clamped = wide[WIDTH] ^ wide[WIDTH-1];
        sum     = wide[WIDTH-1:0];
        if (clamped) begin
            sum = wide[WIDTH] ? MIN_V : MAX_V;
        end
    end

endmodule

// File: rtl/signed_sat_accumulator.sv
// Burst accumulator: sums BURST signed samples with saturation, presents
// the result on a valid/ready output, and counts saturated results.
//
// state | meaning
// ------+----------------------------------------------------------
// ACC   | accepting samples (in_ready=1), accumulating into acc
// OUT   | holding burst result (out_valid=1) until downstream takes it
module signed_sat_accumulator
    import signed_sat_accumulator_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int BURST = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_overflow,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_sat,
    output logic [CNT_W-1:0] sat_cnt
);

    localparam int CW = (BURST > 1) ? $clog2(BURST) : 1;
    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(sat_max(WIDTH));
    localparam logic [WIDTH-1:0] MIN_V = WIDTH'(sat_min(WIDTH));

    acc_state_e       state;
    acc_state_e       state_next;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] sample;
    logic [WIDTH-1:0] sum;
    logic             clamped;
    logic             sat_flag;
    logic [CW-1:0]    cnt;
    logic             in_fire;
    logic             out_fire;
    logic             last;

    assign in_ready  = (state == ACC);
    assign out_valid = (state == OUT);
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;
    assign last      = (cnt == CW'(BURST - 1));
    assign out_data  = acc;
    assign out_sat   = sat_flag;

    // An overflowed upstream sum is replaced by the rail its wrapped sign
    // bit points away from: a wrapped-negative result came from a positive overflow.
    always_comb begin
        sample = in_data;
        if (in_overflow) begin
            sample = in_data[WIDTH-1] ? MAX_V : MIN_V;
        end
    end

    sat_add #(.WIDTH(WIDTH)) u_sat_add (
        .a       (acc),
        .b       (sample),
        .sum     (sum),
        .clamped (clamped)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ACC;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: leave ACC on the last sample of a burst, return on output take.
    always_comb begin
        state_next = state;
        case (state)
            ACC: if (in_fire && last) state_next = OUT;
            OUT: if (out_fire)        state_next = ACC;
            default:                  state_next = ACC;
        endcase
    end

    // Accumulator, sample counter and burst saturation flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc      <= '0;
            cnt      <= '0;
            sat_flag <= 1'b0;
        end else if (out_fire) begin
            acc      <= '0;
            cnt      <= '0;
            sat_flag <= 1'b0;
        end else if (in_fire) begin
            acc      <= sum;
            sat_flag <= sat_flag | in_overflow | clamped;
            if (!last) begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    // Count delivered saturated results, sticking at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            sat_cnt <= '0;
        end else if (out_fire && sat_flag && (sat_cnt != '1)) begin
            sat_cnt <= sat_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_signed_sat_accumulator.sv
// Directed bench for signed_sat_accumulator (WIDTH=4, BURST=4, CNT_W=2).
module tb_signed_sat_accumulator;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_data;
    logic       in_overflow;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_data;
    logic       out_sat;
    logic [1:0] sat_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    signed_sat_accumulator #(.WIDTH(4), .BURST(4), .CNT_W(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_overflow (in_overflow),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_sat     (out_sat),
        .sat_cnt     (sat_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Offer one sample and wait (bounded) until it is accepted; returns #1 after the accepting edge.
    task automatic send(input logic [3:0] d, input logic ovf);
        int t;
        @(negedge clk);
        in_valid    = 1'b1;
        in_data     = d;
        in_overflow = ovf;
        t = 0;
        while (!in_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (t >= 20) check("send_timeout", 32'(t), 32'(0));
        @(posedge clk);
        #1;
        in_valid    = 1'b0;
        in_overflow = 1'b0;
    endtask

    // Four samples; checks out_valid low before the last handshake and high right after it.
    task automatic burst(input string tag, input logic [3:0] s0, input logic o0,
                         input logic [3:0] s1, input logic [3:0] s2, input logic [3:0] s3);
        send(s0, o0);
        send(s1, 1'b0);
        send(s2, 1'b0);
        check({tag, "_ovalid_pre"}, 32'(out_valid), 32'(0));
        send(s3, 1'b0);
        check({tag, "_ovalid"}, 32'(out_valid), 32'(1));
    endtask

    // Check presented result, let it be taken, then check sat_cnt and readiness.
    task automatic take(input string tag, input logic [3:0] exp_d, input logic exp_s,
                        input logic [1:0] exp_cnt);
        check({tag, "_data"}, 32'(out_data), 32'(exp_d));
        check({tag, "_sat"}, 32'(out_sat), 32'(exp_s));
        @(posedge clk);
        #1;
        check({tag, "_satcnt"}, 32'(sat_cnt), 32'(exp_cnt));
        check({tag, "_iready"}, 32'(in_ready), 32'(1));
        check({tag, "_ovalid_clr"}, 32'(out_valid), 32'(0));
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = 4'd0;
        in_overflow = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_iready", 32'(in_ready), 32'(1));
        check("rst_ovalid", 32'(out_valid), 32'(0));
        check("rst_data", 32'(out_data), 32'(0));
        check("rst_sat", 32'(out_sat), 32'(0));
        check("rst_satcnt", 32'(sat_cnt), 32'(0));
        @(negedge clk);
        rst = 1'b0;

        // 1+2-1-2 = 0, no saturation
        burst("b0", 4'd1, 1'b0, 4'd2, 4'hF, 4'hE);
        take("b0", 4'd0, 1'b0, 2'd0);

        // 7, 7->clamp 7, -3 -> 4, +1 -> 5
        burst("b1", 4'd7, 1'b0, 4'd7, 4'hD, 4'd1);
        take("b1", 4'd5, 1'b1, 2'd1);

        // overflowed 4+7 wraps to 1011 -> +7
        burst("b2", 4'b1011, 1'b1, 4'd0, 4'd0, 4'd0);
        take("b2", 4'd7, 1'b1, 2'd2);

        // overflowed -4-7 wraps to 0101 -> -8, then -8 clamps at -8
        burst("b3", 4'b0101, 1'b1, 4'h8, 4'd0, 4'd0);
        take("b3", 4'h8, 1'b1, 2'd3);

        // Downstream stall with upstream holding the next burst's first sample
        out_ready = 1'b0;
        burst("b4", 4'd1, 1'b0, 4'd1, 4'd1, 4'd2);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 4'd3;
        for (int i = 0; i < 3; i++) begin
            check("stall_iready", 32'(in_ready), 32'(0));
            check("stall_ovalid", 32'(out_valid), 32'(1));
            check("stall_data", 32'(out_data), 32'(5));
            check("stall_sat", 32'(out_sat), 32'(0));
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("stall_satcnt", 32'(sat_cnt), 32'(3));
        check("stall_resume_iready", 32'(in_ready), 32'(1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        send(4'd0, 1'b0);
        send(4'd0, 1'b0);
        check("b5_ovalid_pre", 32'(out_valid), 32'(0));
        send(4'd0, 1'b0);
        check("b5_ovalid", 32'(out_valid), 32'(1));
        take("b5", 4'd3, 1'b0, 2'd3);

        // Reset mid-burst discards the partial sum and clears sat_cnt
        send(4'd1, 1'b0);
        send(4'd1, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mrst_data", 32'(out_data), 32'(0));
        check("mrst_sat", 32'(out_sat), 32'(0));
        check("mrst_ovalid", 32'(out_valid), 32'(0));
        check("mrst_iready", 32'(in_ready), 32'(1));
        check("mrst_satcnt", 32'(sat_cnt), 32'(0));
        @(negedge clk);
        rst = 1'b0;
        burst("b6", 4'd1, 1'b0, 4'd1, 4'd1, 4'd1);
        take("b6", 4'd4, 1'b0, 2'd0);

        // Five saturated bursts: sat_cnt climbs to 3 and sticks
        for (int k = 0; k < 5; k++) begin
            burst("sc", 4'd7, 1'b0, 4'd7, 4'd0, 4'd0);
            take("sc", 4'd7, 1'b1, (k < 3) ? 2'(k + 1) : 2'd3);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
